traffic_engine: RTL and testbench

Parametrised lane-traffic generator for the frog game. It replaces the fixed set of per-car instances and the separate slow-clock divider with one block. The block holds NUM_CARS car positions on a GRID_COLS-wide playfield and steps each car at a level-dependent rate. It reports frog/car collisions with a sequential scan and answers a registered cell-occupancy query for the VGA renderer. It sits between the level counter (i_Level) and the frog controller / VGA display.

---
 rtl/traffic_engine.sv | 154 +++++++++++++++
 tb/tb_traffic_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_engine.sv
// -----------------------------------------------------------------------------
// traffic_engine
//   Lane-traffic generator for the frog game. Holds NUM_CARS car positions on
//   a GRID_COLS-wide playfield and steps each car at a level-dependent rate
//   derived from a shared movement-tick prescaler. A round-robin scan checks
//   one car per cycle against the frog cell and pulses o_Collision at the end
//   of each scan. A registered occupancy query serves the VGA renderer.
//
// Ports
//   i_Clk        sole clock
//   i_Reset      synchronous, active-high reset
//   i_Enable     1 = traffic and scan run, 0 = everything frozen
//   i_Level      current level; subtracts from each car's base period
//   i_Frog_Col   frog column        i_Frog_Row   frog row
//   i_Query_Col  renderer column    i_Query_Row  renderer row
//   o_Car_X      packed car columns, car k at [k*COL_W +: COL_W]
//   o_Car_Row    packed car rows (constant, equals CAR_ROWS)
//   o_Tick       one-cycle pulse per movement tick
//   o_Collision  one-cycle pulse after a scan in which a car held the frog cell
//   o_Query_Hit  registered: a car occupies the query cell (1-cycle lag)
// -----------------------------------------------------------------------------
module traffic_engine #(
    parameter int NUM_CARS  = 16,
    parameter int GRID_COLS = 20,
    parameter int COL_W     = 5,
    parameter int ROW_W     = 4,
    parameter int TICK_DIV  = 900000,
    parameter logic [NUM_CARS*ROW_W-1:0] CAR_ROWS    = {NUM_CARS{ROW_W'(1)}},
    parameter logic [NUM_CARS*COL_W-1:0] CAR_STARTS  = '0,
    parameter logic [NUM_CARS-1:0]       CAR_DIRS    = {NUM_CARS{1'b1}},
    parameter logic [NUM_CARS*8-1:0]     CAR_PERIODS = {NUM_CARS{8'd4}}
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Enable,
    input  logic [3:0]                i_Level,
    input  logic [COL_W-1:0]          i_Frog_Col,
    input  logic [ROW_W-1:0]          i_Frog_Row,
    input  logic [COL_W-1:0]          i_Query_Col,
    input  logic [ROW_W-1:0]          i_Query_Row,
    output logic [NUM_CARS*COL_W-1:0] o_Car_X,
    output logic [NUM_CARS*ROW_W-1:0] o_Car_Row,
    output logic                      o_Tick,
    output logic                      o_Collision,
    output logic                      o_Query_Hit
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CARS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_COLS - 1);

    logic [PRE_W-1:0]    pre_cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                hit_acc_reg;
    logic                collision_reg;
    logic                query_hit_reg;
    logic                tick;
    logic [NUM_CARS-1:0] frog_match;
    logic [NUM_CARS-1:0] query_match;

    // The tick is decoded straight from the prescaler so that the tick cycle
    // itself is the edge on which the cars move.
    assign tick = i_Enable && !i_Reset && (pre_cnt_reg == PRE_LAST);

    // Prescaler and collision scan share one enable, so both freeze together.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pre_cnt_reg   <= '0;
            idx_reg       <= '0;
            hit_acc_reg   <= 1'b0;
            collision_reg <= 1'b0;
        end else if (i_Enable) begin
            pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;
            if (idx_reg == IDX_LAST) begin
                // Fold in the last car's compare directly; the accumulator
                // restarts clean for the next scan.
                collision_reg <= hit_acc_reg | frog_match[idx_reg];
                hit_acc_reg   <= 1'b0;
                idx_reg       <= '0;
            end else begin
                collision_reg <= 1'b0;
                hit_acc_reg   <= hit_acc_reg | frog_match[idx_reg];
                idx_reg       <= idx_reg + 1'b1;
            end
        end else begin
            collision_reg <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            query_hit_reg <= 1'b0;
        end else begin
            query_hit_reg <= |query_match;
        end
    end

    for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
        localparam logic [ROW_W-1:0] ROW    = CAR_ROWS[gi*ROW_W +: ROW_W];
        localparam logic [COL_W-1:0] START  = CAR_STARTS[gi*COL_W +: COL_W];
        localparam logic [7:0]       PERIOD = CAR_PERIODS[gi*8 +: 8];
        localparam logic             RIGHT  = CAR_DIRS[gi];

        logic [COL_W-1:0] x_reg;
        logic [COL_W-1:0] x_next;
        logic [7:0]       step_reg;
        logic [8:0]       step_inc;
        logic [8:0]       eff;

        always_comb begin
            // Compare before subtracting so the period never underflows;
            // anything at or below the level clamps to one tick per step.
            eff = 9'd1;
            if (PERIOD > {4'd0, i_Level}) begin
                eff = {1'b0, PERIOD - {4'd0, i_Level}};
            end
            step_inc = {1'b0, step_reg} + 9'd1;
            x_next   = x_reg;
            if (RIGHT) begin
                x_next = (x_reg == COL_LAST) ? '0 : x_reg + 1'b1;
            end else begin
                x_next = (x_reg == '0) ? COL_LAST : x_reg - 1'b1;
            end
        end

        // ">=" rather than "==" so a level raise that leaves step_reg past
        // the new period still steps on the very next tick.
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                x_reg    <= START;
                step_reg <= 8'd0;
            end else if (tick) begin
                if (step_inc >= eff) begin
                    x_reg    <= x_next;
                    step_reg <= 8'd0;
                end else begin
                    step_reg <= step_inc[7:0];
                end
            end
        end

        assign frog_match[gi]  = (x_reg == i_Frog_Col)  && (ROW == i_Frog_Row);
        assign query_match[gi] = (x_reg == i_Query_Col) && (ROW == i_Query_Row);
        assign o_Car_X[gi*COL_W +: COL_W] = x_reg;
    end

    assign o_Car_Row   = CAR_ROWS;
    assign o_Tick      = tick;
    assign o_Collision = collision_reg;
    assign o_Query_Hit = query_hit_reg;

endmodule

// File: tb/tb_traffic_engine.sv
// -----------------------------------------------------------------------------
// tb_traffic_engine
//   Directed bench for traffic_engine with four cars, TICK_DIV=4.
//   car0: (19,row1) right, period 1   -> wrap-around and every-tick stepping
//   car1: ( 7,row2) left,  period 5   -> level speed-up and clamp
//   car2: ( 6,row3) right, period 255 -> stationary collision target
//   car3: ( 3,row5) left,  period 255 -> stationary
//   With TICK_DIV equal to NUM_CARS the scan index always equals the
//   prescaler count, so collision pulses land on the samples right after
//   each tick update.
// -----------------------------------------------------------------------------
module tb_traffic_engine;

    localparam int NC = 4;
    localparam int CW = 5;
    localparam int RW = 4;
    localparam logic [NC*RW-1:0] ROWS    = {4'd5, 4'd3, 4'd2, 4'd1};
    localparam logic [NC*CW-1:0] STARTS  = {5'd3, 5'd6, 5'd7, 5'd19};
    localparam logic [NC-1:0]    DIRS    = 4'b0101;
    localparam logic [NC*8-1:0]  PERIODS = {8'd255, 8'd255, 8'd5, 8'd1};

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [3:0]       level;
    logic [CW-1:0]    frog_col;
    logic [RW-1:0]    frog_row;
    logic [CW-1:0]    q_col;
    logic [RW-1:0]    q_row;
    logic [NC*CW-1:0] car_x;
    logic [NC*RW-1:0] car_row;
    logic             tick;
    logic             coll;
    logic             q_hit;

    int vectors = 0;
    int miscompares = 0;

    traffic_engine #(
        .NUM_CARS(NC), .GRID_COLS(20), .COL_W(CW), .ROW_W(RW), .TICK_DIV(4),
        .CAR_ROWS(ROWS), .CAR_STARTS(STARTS), .CAR_DIRS(DIRS),
        .CAR_PERIODS(PERIODS)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Level(level),
        .i_Frog_Col(frog_col), .i_Frog_Row(frog_row),
        .i_Query_Col(q_col), .i_Query_Row(q_row),
        .o_Car_X(car_x), .o_Car_Row(car_row), .o_Tick(tick),
        .o_Collision(coll), .o_Query_Hit(q_hit)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xk(input int k);
        return 32'(car_x[k*CW +: CW]);
    endfunction

    // One full tick period starting from prescaler=0; ends on the sample
    // where the tick's position update and any scan pulse are visible.
    task automatic tick_once(input string tag, input logic exp_coll);
        step(1); check({tag, " tick@1"}, tick, 0); check({tag, " coll@1"}, coll, 0);
        step(1); check({tag, " tick@2"}, tick, 0); check({tag, " coll@2"}, coll, 0);
        step(1); check({tag, " tick@3"}, tick, 1); check({tag, " coll@3"}, coll, 0);
        step(1); check({tag, " tick@0"}, tick, 0); check({tag, " coll@0"}, coll, exp_coll);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; level = 4'd0;
        frog_col = 5'd0; frog_row = 4'd15;
        q_col = 5'd0; q_row = 4'd15;

        // Reset state
        step(2);
        check("reset car_x", car_x, STARTS);
        check("reset car_row", car_row, ROWS);
        check("reset tick", tick, 0);
        check("reset coll", coll, 0);
        check("reset qhit", q_hit, 0);

        // Query: car1 start cell, registered one cycle later
        rst = 1'b0;
        q_col = 5'd7; q_row = 4'd2;
        #1 check("query lag", q_hit, 0);
        step(1); check("query car1", q_hit, 1);
        q_col = 5'd8; q_row = 4'd2;
        step(1); check("query empty", q_hit, 0);
        q_col = 5'd6; q_row = 4'd3;
        step(1); check("query car2", q_hit, 1);
        q_col = 5'd6; q_row = 4'd4;
        step(1); check("query wrong row", q_hit, 0);

        // Enable: first tick at enabled cycle 3, move visible one cycle later
        en = 1'b1;
        step(3);
        check("t1 tick", tick, 1);
        check("t1 x0 before move", xk(0), 19);
        step(1);
        check("t1 x0 wrap", xk(0), 0);
        check("t1 tick off", tick, 0);
        tick_once("t2", 1'b0);
        check("t2 x0", xk(0), 1);

        // Level 0: car1 (period 5) steps on ticks 5 and 10
        tick_once("t3", 1'b0);
        tick_once("t4", 1'b0);
        check("t4 x1", xk(1), 7);
        tick_once("t5", 1'b0);
        check("t5 x1", xk(1), 6);
        for (int t = 6; t <= 9; t++) tick_once("t6-9", 1'b0);
        check("t9 x1", xk(1), 6);
        tick_once("t10", 1'b0);
        check("t10 x1", xk(1), 5);

        // Level 2: effective period 3
        level = 4'd2;
        tick_once("t11", 1'b0);
        tick_once("t12", 1'b0);
        check("t12 x1", xk(1), 5);
        tick_once("t13", 1'b0);
        check("t13 x1", xk(1), 4);

        // Level 9: clamped to one tick per step
        level = 4'd9;
        tick_once("t14", 1'b0);
        check("t14 x1", xk(1), 3);
        tick_once("t15", 1'b0);
        check("t15 x1", xk(1), 2);
        check("t15 x0", xk(0), 14);
        check("t15 x2 still", xk(2), 6);

        // Pause for 50 cycles with the frog sitting on car2
        en = 1'b0;
        frog_col = 5'd6; frog_row = 4'd3;
        for (int c = 0; c < 50; c++) begin
            step(1);
            check("pause tick", tick, 0);
            check("pause coll", coll, 0);
        end
        check("pause x0", xk(0), 14);
        check("pause x1", xk(1), 2);

        // Resume: prescaler and scan index picked up exactly where they froze
        en = 1'b1;
        tick_once("t16", 1'b1);
        check("t16 x0", xk(0), 15);
        check("t16 x1", xk(1), 1);

        // Persistent overlap: pulse every 4 cycles
        level = 4'd0;
        tick_once("t17", 1'b1);
        tick_once("t18", 1'b1);

        // Frog steps off: no more pulses
        frog_col = 5'd6; frog_row = 4'd4;
        tick_once("t19", 1'b0);
        tick_once("t20", 1'b0);
        check("t20 x0", xk(0), 19);
        check("t20 x1", xk(1), 1);

        // Overlap with car0, then reset while scan index is 1
        frog_col = 5'd19; frog_row = 4'd1;
        step(1);
        rst = 1'b1;
        step(1);
        check("rst mid car_x", car_x, STARTS);
        check("rst mid coll", coll, 0);
        check("rst mid tick", tick, 0);
        rst = 1'b0;
        step(1); check("post rst coll1", coll, 0);
        step(1); check("post rst coll2", coll, 0);
        step(1); check("post rst coll3", coll, 0);
        check("post rst tick", tick, 1);
        step(1); check("post rst new scan", coll, 1);
        check("post rst x0 wrap", xk(0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
